// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access with req/ack handshake, timeout recovery and MEM/WB register
module mem_wb_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_M,
  input  logic        mem_to_reg_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic [4:0]  write_reg_M,
  input  logic [4:0]  addressP1_M,
  input  logic        jump_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_M,
  output logic        reg_write_W,
  output logic [4:0]  write_reg_W,
  output logic [31:0] result_W,
  output logic        dmem_err
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  logic [0:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_reg_write;
  logic [4:0]  r_write_reg;
  logic [31:0] r_result;
  logic        w_memop;
  logic        w_load;
  logic        w_timeout;
  logic        w_bubble;
  logic [31:0] w_result;
  assign w_memop    = mem_to_reg_M | mem_write_M;
  assign dmem_req   = w_memop & ~reset;
  assign dmem_we    = mem_write_M;
  assign dmem_addr  = alu_out_M;
  assign dmem_wdata = write_data_M;
  assign stall_M    = dmem_req & ~dmem_ack;
  assign w_timeout  = (r_state == S_WAIT) & stall_M & (r_cnt == 8'(TIMEOUT));
  // the forced-completion cycle still shows stall but commits the instruction
  assign w_bubble   = stall_M & ~w_timeout;
  assign w_load     = mem_to_reg_M & ~mem_write_M;
  assign w_result   = jump_M ? {27'b0, addressP1_M} :
                      w_load ? (w_timeout ? 32'b0 : dmem_rdata) : alu_out_M;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_memop & ~dmem_ack) begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd1;
        end
      end else if (~w_memop | dmem_ack | w_timeout) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_write <= 1'b0;
      r_write_reg <= '0;
      r_result    <= '0;
    end else begin
      r_reg_write <= w_bubble ? 1'b0 : reg_write_M & (write_reg_M != 5'd0);
      r_write_reg <= w_bubble ? 5'd0 : write_reg_M;
      r_result    <= w_bubble ? 32'd0 : w_result;
    end
  end
  assign reg_write_W = r_reg_write;
  assign write_reg_W = r_write_reg;
  assign result_W    = r_result;
  assign dmem_err    = r_err;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scenario tasks with a write-back scoreboard queue for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_M, mem_to_reg_M, mem_write_M, jump_M;
  logic [31:0] alu_out_M, write_data_M, dmem_rdata;
  logic [4:0]  write_reg_M, addressP1_M;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall_M, reg_write_W, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, result_W;
  logic [4:0]  write_reg_W;
  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
  } wb_t;
  wb_t q[$];
  wb_t e;
  int checks = 0;
  int fails = 0;
  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .reg_write_M(reg_write_M), .mem_to_reg_M(mem_to_reg_M), .mem_write_M(mem_write_M),
    .alu_out_M(alu_out_M), .write_data_M(write_data_M), .write_reg_M(write_reg_M),
    .addressP1_M(addressP1_M), .jump_M(jump_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_M(stall_M),
    .reg_write_W(reg_write_W), .write_reg_W(write_reg_W), .result_W(result_W),
    .dmem_err(dmem_err)
  );
  always #5 clk = ~clk;
  task automatic set_m(input logic rw, input logic mtr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr, input logic [4:0] ap1,
                       input logic j);
    reg_write_M = rw; mem_to_reg_M = mtr; mem_write_M = mw; alu_out_M = alu;
    write_data_M = wd; write_reg_M = wr; addressP1_M = ap1; jump_M = j;
  endtask
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    set_m(1, 1, 0, 32'h40, 0, 5'd3, 0, 0);
    #2;
    checks++;
    if ({dmem_req, stall_M, reg_write_W, write_reg_W, result_W, dmem_err} !== 40'd0) begin
      fails++;
      $display("FAIL reset: got req=%0b stall=%0b rw=%0b rd=%0d res=%h err=%0b want all 0",
               dmem_req, stall_M, reg_write_W, write_reg_W, result_W, dmem_err);
    end
    edge_step();
    edge_step();
    reset = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_alu();
    set_m(1, 0, 0, 32'h1234, 0, 5'd5, 0, 0);
    q.push_back('{1'b1, 5'd5, 32'h1234});
    #1;
    checks++;
    if (stall_M !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL alu_stall: got stall=%0b req=%0b want 0/0", stall_M, dmem_req);
    end
    edge_step();
    e = q.pop_front(); checks++;
    if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
      fails++;
      $display("FAIL alu_w: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
               reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
    end
  endtask
  task automatic test_load_wait();
    set_m(1, 1, 0, 32'h40, 0, 5'd3, 0, 0);
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h11111111;
      q.push_back(c == 3 ? '{1'b1, 5'd3, 32'hDEADBEEF} : '{1'b0, 5'd0, 32'd0});
      #1;
      checks++;
      if (stall_M !== (c < 3) || dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin
        fails++;
        $display("FAIL load_ctl c%0d: got stall=%0b req=%0b we=%0b addr=%h want %0b/1/0/00000040",
                 c, stall_M, dmem_req, dmem_we, dmem_addr, c < 3);
      end
      edge_step();
      e = q.pop_front(); checks++;
      if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
        fails++;
        $display("FAIL load_w c%0d: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
                 c, reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
      end
    end
    dmem_ack = 1'b0;
  endtask
  task automatic test_store_zero_wait();
    set_m(0, 0, 1, 32'h10, 32'hA5, 5'd0, 0, 0);
    dmem_ack = 1'b1;
    q.push_back('{1'b0, 5'd0, 32'h10});
    #1;
    checks++;
    if ({dmem_req, dmem_we, stall_M} !== 3'b110 || dmem_addr !== 32'h10 || dmem_wdata !== 32'hA5) begin
      fails++;
      $display("FAIL store_ctl: got req=%0b we=%0b stall=%0b addr=%h wdata=%h want 1/1/0/10/a5",
               dmem_req, dmem_we, stall_M, dmem_addr, dmem_wdata);
    end
    edge_step();
    e = q.pop_front(); checks++;
    if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
      fails++;
      $display("FAIL store_w: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
               reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
    end
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_M !== 1'b0) begin
      fails++; $display("FAIL store_after: got req=%0b stall=%0b want 0/0", dmem_req, stall_M);
    end
    dmem_ack = 1'b0;
    edge_step();
  endtask
  task automatic test_timeout(input logic ack_last, input logic [4:0] wr, input logic [31:0] rd);
    set_m(1, 1, 0, 32'h80, 0, wr, 0, 0);
    for (int c = 0; c < 5; c++) begin
      dmem_ack = ack_last && (c == 4);
      dmem_rdata = rd;
      q.push_back(c == 4 ? '{1'b1, wr, ack_last ? rd : 32'd0} : '{1'b0, 5'd0, 32'd0});
      #1;
      checks++;
      if (stall_M !== !(ack_last && c == 4)) begin
        fails++;
        $display("FAIL tmo_stall ack=%0b c%0d: got %0b want %0b", ack_last, c, stall_M, !(ack_last && c == 4));
      end
      edge_step();
      e = q.pop_front(); checks++;
      if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
        fails++;
        $display("FAIL tmo_w ack=%0b c%0d: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
                 ack_last, c, reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
      end
    end
    dmem_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) edge_step();
    checks++;
    if (dmem_err !== !ack_last || stall_M !== 1'b0) begin
      fails++;
      $display("FAIL tmo_err ack=%0b: got err=%0b stall=%0b want %0b/0", ack_last, dmem_err, stall_M, !ack_last);
    end
  endtask
  task automatic test_err_clear();
    reset = 1'b1;
    #1;
    checks++;
    if (dmem_err !== 1'b0) begin
      fails++; $display("FAIL err_clear: got %0b want 0", dmem_err);
    end
    #1 reset = 1'b0;
    edge_step();
  endtask
  task automatic test_jump_and_reg0();
    set_m(1, 0, 0, 32'h999, 0, 5'd31, 5'd7, 1);
    q.push_back('{1'b1, 5'd31, 32'd7});
    edge_step();
    e = q.pop_front(); checks++;
    if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
      fails++;
      $display("FAIL jump_w: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
               reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
    end
    set_m(1, 0, 0, 32'h55, 0, 5'd0, 0, 0);
    q.push_back('{1'b0, 5'd0, 32'h55});
    edge_step();
    e = q.pop_front(); checks++;
    if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
      fails++;
      $display("FAIL reg0_w: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
               reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
    end
  endtask
  task automatic test_reset_in_wait();
    set_m(1, 1, 0, 32'h44, 0, 5'd9, 0, 0);
    repeat (2) edge_step();
    #1;
    checks++;
    if (stall_M !== 1'b1) begin
      fails++; $display("FAIL rst_wait_pre: got stall=%0b want 1", stall_M);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dmem_req, stall_M, reg_write_W, write_reg_W, result_W} !== 39'd0) begin
      fails++;
      $display("FAIL rst_wait: got req=%0b stall=%0b rw=%0b rd=%0d res=%h want all 0",
               dmem_req, stall_M, reg_write_W, write_reg_W, result_W);
    end
    #2 reset = 1'b0;
    set_m(1, 0, 0, 32'hBEEF, 0, 5'd4, 0, 0);
    q.push_back('{1'b1, 5'd4, 32'hBEEF});
    edge_step();
    e = q.pop_front(); checks++;
    if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
      fails++;
      $display("FAIL rst_wait_next: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
               reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
    end
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      dmem_ack = 1'b1;
      dmem_rdata = 32'h100 * (c + 1);
      if (c < 2) begin
        set_m(1, 1, 0, 32'h200 + c, 0, 5'(10 + c), 0, 0);
        q.push_back('{1'b1, 5'(10 + c), 32'h100 * (c + 1)});
      end else begin
        set_m(1, 0, 0, 32'h77 + c, 0, 5'd2, 0, 0);
        q.push_back('{1'b1, 5'd2, 32'h77 + c});
      end
      #1;
      checks++;
      if (dmem_req !== (c < 2) || stall_M !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ctl c%0d: got req=%0b stall=%0b want %0b/0", c, dmem_req, stall_M, c < 2);
      end
      edge_step();
      e = q.pop_front(); checks++;
      if ({reg_write_W, write_reg_W, result_W} !== {e.rw, e.wr, e.res}) begin
        fails++;
        $display("FAIL b2b_w c%0d: got rw=%0b rd=%0d res=%h want rw=%0b rd=%0d res=%h",
                 c, reg_write_W, write_reg_W, result_W, e.rw, e.wr, e.res);
      end
    end
    dmem_ack = 1'b0;
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_zero_wait();
    test_timeout(1'b0, 5'd7, 32'h12345678);
    test_err_clear();
    test_timeout(1'b1, 5'd8, 32'hCAFEF00D);
    test_jump_and_reg0();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
